pc_fetch_unit: RTL and testbench

Instruction fetch front end that generates the PC stream and consumes the branch/jump resolution produced by the execute-stage ALU (taken flag plus target).
- Issues in-order requests to instruction memory over a valid/ready channel.
- Buffers returned instructions with their PCs and hands them to decode over a valid/ready channel.
- Squashes wrong-path fetches on every taken redirect.

---
 rtl/rv_fetch_pkg.sv | 10 +
 rtl/fetch_fifo.sv | 43 ++++
 rtl/pc_fetch_unit.sv | 68 ++++++
 tb/tb_pc_fetch_unit.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_fetch_pkg.sv
// rv_fetch_pkg: fetch front-end defaults, FSM state type, instruction size and control-flow opcodes shared with execute
package rv_fetch_pkg;
  localparam int DEF_XLEN = 32;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam int INST_BYTES = 4;
  localparam logic [6:0] OPC_JAL = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  typedef enum logic [1:0] {BOOT, RUN, HALT} fetch_state_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: sync FIFO (push/pop/flush/din in; dout=head, count, full, empty out), async active-low reset, power-of-2 DEPTH
module fetch_fifo #(
  parameter int W = 32,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rd];
  always_ff @(posedge clk)
    if (do_push) mem[wr] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else if (flush) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else begin
      wr <= wr + AW'(do_push);
      rd <= rd + AW'(do_pop);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC generator + imem req/rsp + decode handoff with redirect squash (in: redirect_valid/target, imem_req_ready, imem_rsp_valid/data, inst_ready; out: imem_req_valid/addr, inst_valid/data/pc, misalign_err)
module pc_fetch_unit import rv_fetch_pkg::*; #(
  parameter int XLEN = DEF_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEF_RESET_PC),
  parameter int BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst_data,
  output logic [XLEN-1:0] inst_pc,
  output logic            misalign_err
);
  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam int SW = CW + 1;
  localparam int DW = CW + 3;
  fetch_state_t state, state_d;
  logic [XLEN-1:0] pc, if_head;
  logic [XLEN+31:0] buf_head;
  logic [CW-1:0] if_count, buf_count;
  logic [DW-1:0] drop_cnt, drop_d, outstanding;
  logic if_full, if_empty, buf_full, buf_empty;
  logic aligned, req_fire, rsp_take, rsp_drop;
  assign aligned = redirect_target[1:0] == 2'b00;
  assign imem_req_valid = state == RUN && !redirect_valid && !if_full && ({1'b0, if_count} + {1'b0, buf_count} < SW'(BUF_DEPTH));
  assign imem_req_addr = pc;
  assign req_fire = imem_req_valid && imem_req_ready;
  assign rsp_drop = imem_rsp_valid && drop_cnt != '0;
  assign rsp_take = imem_rsp_valid && drop_cnt == '0 && !if_empty;
  assign inst_valid = !buf_empty && !redirect_valid;
  assign {inst_pc, inst_data} = buf_empty ? '0 : buf_head;
  assign outstanding = DW'(if_count) + drop_cnt + DW'(req_fire);
  always_comb begin
    state_d = redirect_valid ? (aligned ? RUN : HALT) : (state == BOOT ? RUN : state);
    drop_d = redirect_valid ? outstanding - DW'(imem_rsp_valid && outstanding != '0) : drop_cnt - DW'(rsp_drop);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= BOOT;
    else state <= state_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc <= RESET_PC;
      drop_cnt <= '0;
      misalign_err <= 1'b0;
    end else begin
      drop_cnt <= drop_d;
      if (redirect_valid) misalign_err <= !aligned;
      if (redirect_valid && aligned) pc <= redirect_target;
      else if (req_fire) pc <= pc + XLEN'(INST_BYTES);
    end
  fetch_fifo #(.W(XLEN), .DEPTH(BUF_DEPTH)) u_inflight (
    .clk(clk), .rst_n(rst_n), .push(req_fire), .pop(rsp_take), .flush(redirect_valid),
    .din(pc), .dout(if_head), .count(if_count), .full(if_full), .empty(if_empty)
  );
  fetch_fifo #(.W(XLEN + 32), .DEPTH(BUF_DEPTH)) u_buf (
    .clk(clk), .rst_n(rst_n), .push(rsp_take && !redirect_valid && !buf_full), .pop(inst_valid && inst_ready),
    .flush(redirect_valid), .din({if_head, imem_rsp_data}), .dout(buf_head), .count(buf_count),
    .full(buf_full), .empty(buf_empty)
  );
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: randomized bench for pc_fetch_unit with a queue-based reference model and a scripted memory
module tb_pc_fetch_unit;
  localparam int DEPTH = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic imem_req_valid;
  logic imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic inst_valid;
  logic inst_ready = 1'b0;
  logic [31:0] inst_data, inst_pc;
  logic misalign_err;
  always #5 clk = ~clk;
  pc_fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc), .misalign_err(misalign_err)
  );
  typedef struct {logic [31:0] pc; bit live; int due;} req_t;
  typedef struct {logic [31:0] pc; logic [31:0] data;} ins_t;
  req_t outq[$];
  ins_t bufq[$];
  logic [31:0] m_pc;
  bit m_boot, m_halt, m_mis;
  int cyc, checks, errors;
  int p_rdy = 100, p_inst = 100, p_redir = 0, p_mis = 0, lat_min = 1, lat_max = 1;
  bit redir_once;
  logic [31:0] redir_tgt;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  function automatic int live_cnt();
    int n = 0;
    foreach (outq[i]) if (outq[i].live) n++;
    return n;
  endfunction
  task automatic reset_now(input string tag);
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    inst_ready = 1'b0;
    #1;
    chk({tag, "_req_valid"}, imem_req_valid, 0);
    chk({tag, "_req_addr"}, imem_req_addr, 32'h0);
    chk({tag, "_inst_valid"}, inst_valid, 0);
    chk({tag, "_misalign"}, misalign_err, 0);
    chk({tag, "_inst_pc"}, inst_pc, 0);
    chk({tag, "_inst_data"}, inst_data, 0);
    outq.delete();
    bufq.delete();
    m_pc = 32'h0;
    m_boot = 1;
    m_halt = 0;
    m_mis = 0;
    @(posedge clk);
  endtask
  task automatic step();
    bit rv, mis, exp_rv, exp_iv;
    logic [31:0] t;
    req_t r;
    @(negedge clk);
    rst_n = 1'b1;
    mis = $urandom_range(0, 99) < p_mis;
    t = ($urandom & 32'h0000_0FFC) | (mis ? 32'($urandom_range(1, 3)) : 32'h0);
    rv = redir_once || ($urandom_range(0, 999) < p_redir);
    redirect_valid = rv;
    redirect_target = redir_once ? redir_tgt : t;
    imem_req_ready = $urandom_range(0, 99) < p_rdy;
    inst_ready = $urandom_range(0, 99) < p_inst;
    imem_rsp_valid = outq.size() > 0 && outq[0].due <= cyc;
    imem_rsp_data = $urandom;
    #1;
    exp_rv = !m_boot && !m_halt && !rv && (live_cnt() + bufq.size() < DEPTH);
    exp_iv = bufq.size() > 0 && !rv;
    chk("req_valid", imem_req_valid, exp_rv);
    chk("req_addr", imem_req_addr, m_pc);
    chk("inst_valid", inst_valid, exp_iv);
    chk("misalign_err", misalign_err, m_mis);
    if (bufq.size() > 0) begin
      chk("inst_pc", inst_pc, bufq[0].pc);
      chk("inst_data", inst_data, bufq[0].data);
    end
    if (exp_iv && inst_ready) void'(bufq.pop_front());
    if (imem_rsp_valid) begin
      r = outq.pop_front();
      if (r.live && !rv) bufq.push_back('{r.pc, imem_rsp_data});
    end
    if (exp_rv && imem_req_ready) begin
      outq.push_back('{m_pc, 1'b1, cyc + int'($urandom_range(lat_min, lat_max))});
      m_pc += 32'd4;
    end
    m_boot = 0;
    if (rv) begin
      foreach (outq[i]) outq[i].live = 0;
      bufq.delete();
      m_mis = redirect_target[1:0] != 2'b00;
      m_halt = m_mis;
      if (!m_mis) m_pc = redirect_target;
    end
    cyc++;
    redir_once = 0;
  endtask
  task automatic redirect_to(input logic [31:0] tgt);
    redir_once = 1;
    redir_tgt = tgt;
    step();
  endtask
  task automatic wait_req(input string name, input logic [31:0] exp);
    for (int i = 0; i < 20; i++) begin
      step();
      if (imem_req_valid && imem_req_ready) begin
        chk(name, imem_req_addr, exp);
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL %s: no request within 20 cycles, expected addr %h", name, exp);
  endtask
  task automatic wait_inst(input string name, input logic [31:0] exp);
    for (int i = 0; i < 20; i++) begin
      step();
      if (inst_valid && inst_ready) begin
        chk(name, inst_pc, exp);
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL %s: no instruction within 20 cycles, expected pc %h", name, exp);
  endtask
  initial begin
    int n;
    @(negedge clk);
    reset_now("rst");
    step();
    chk("boot_no_req", imem_req_valid, 0);
    step();
    chk("first_req_valid", imem_req_valid, 1);
    chk("first_req_addr", imem_req_addr, 32'h0);
    step();
    chk("second_req_addr", imem_req_addr, 32'h4);
    chk("no_inst_at_t1", inst_valid, 0);
    step();
    chk("inst_at_t2", inst_valid, 1);
    chk("inst_pc_t2", inst_pc, 32'h0);
    chk("credit_stall", imem_req_valid, 0);
    step();
    chk("third_req_valid", imem_req_valid, 1);
    chk("third_req_addr", imem_req_addr, 32'h8);
    chk("inst_pc_t3", inst_pc, 32'h4);
    @(negedge clk);
    reset_now("rst2");
    p_inst = 0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (imem_req_valid && imem_req_ready) n++;
    end
    chk("stall_req_count", n, 2);
    chk("stall_req_valid", imem_req_valid, 0);
    p_inst = 100;
    step();
    chk("drain0_valid", inst_valid, 1);
    chk("drain0_pc", inst_pc, 32'h0);
    chk("drain0_noreq", imem_req_valid, 0);
    step();
    chk("drain1_pc", inst_pc, 32'h4);
    chk("resume_valid", imem_req_valid, 1);
    chk("resume_addr", imem_req_addr, 32'h8);
    lat_min = 3;
    lat_max = 3;
    redirect_to(32'h10);
    step();
    chk("fetch10_addr", imem_req_addr, 32'h10);
    step();
    chk("fetch14_addr", imem_req_addr, 32'h14);
    redirect_to(32'h100);
    chk("redir_cancels_req", imem_req_valid, 0);
    chk("redir_blocks_inst", inst_valid, 0);
    step();
    chk("redir_next_valid", imem_req_valid, 1);
    chk("redir_next_addr", imem_req_addr, 32'h100);
    wait_inst("redir_first_inst", 32'h100);
    lat_min = 1;
    lat_max = 1;
    redirect_to(32'h102);
    step();
    chk("misalign_set", misalign_err, 1);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      n += int'(imem_req_valid | inst_valid);
    end
    chk("halt_quiet", n, 0);
    redirect_to(32'h200);
    step();
    chk("misalign_clear", misalign_err, 0);
    chk("halt_exit_valid", imem_req_valid, 1);
    chk("halt_exit_addr", imem_req_addr, 32'h200);
    redirect_to(32'h20);
    step();
    chk("fetch20_addr", imem_req_addr, 32'h20);
    redirect_to(32'h300);
    chk("rsp_redir_noreq", imem_req_valid, 0);
    wait_inst("drop_first_inst", 32'h300);
    redirect_to(32'hFFFF_FFF8);
    wait_req("wrap0", 32'hFFFF_FFF8);
    wait_req("wrap1", 32'hFFFF_FFFC);
    wait_req("wrap2", 32'h0000_0000);
    for (int i = 0; i < 20 && !inst_valid; i++) step();
    chk("pre_reset_inst_valid", inst_valid, 1);
    #1;
    reset_now("midrst");
    step();
    chk("midrst_boot_no_req", imem_req_valid, 0);
    step();
    chk("midrst_restart_valid", imem_req_valid, 1);
    chk("midrst_restart_addr", imem_req_addr, 32'h0);
    p_rdy = 70;
    p_inst = 70;
    lat_min = 1;
    lat_max = 4;
    p_redir = 30;
    p_mis = 20;
    for (int i = 0; i < 4000; i++) begin
      step();
      if (i == 2000) begin
        #1;
        reset_now("randrst");
      end
    end
    p_redir = 0;
    for (int i = 0; i < 20; i++) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end
endmodule
